// File: rtl/uc_cmd_if.sv
// uc_cmd_if
//   Command/status bundle between the serial command receiver and the
//   ultrasonic generator controller (uc_cmd_ctrl).
//
//   cmd       [4:0] decoded command code (0..20 step, 21 RUN, 22 STOP,
//                   23 SWEEP, 24 LOCK, 25..31 invalid)
//   cmd_stb         one-cycle strobe, cmd valid while high
//   freq_idx  [4:0] frequency step driven to the NCO (0..20 = 30..40 kHz)
//   drv_en          drive enable
//   sweeping        high while sweeping
//   locked          high while frequency-locked
//   cmd_err         one-cycle pulse on an invalid code
//   wdog_trip       one-cycle pulse on a command-silence timeout
//
//   master : command source side
//   slave  : controller side
interface uc_cmd_if;
  logic [4:0] cmd;
  logic       cmd_stb;
  logic [4:0] freq_idx;
  logic       drv_en;
  logic       sweeping;
  logic       locked;
  logic       cmd_err;
  logic       wdog_trip;

  modport master (
    output cmd, cmd_stb,
    input  freq_idx, drv_en, sweeping, locked, cmd_err, wdog_trip
  );

  modport slave (
    input  cmd, cmd_stb,
    output freq_idx, drv_en, sweeping, locked, cmd_err, wdog_trip
  );
endinterface

// File: rtl/uc_cmd_ctrl.sv
// uc_cmd_ctrl
//   Generator-side controller for the ultrasonic drive. Takes decoded
//   command codes from the serial receiver and sequences the drive through
//   IDLE, fixed-frequency RUN, triangular SWEEP and frequency LOCK.
//
//   Parameters
//     SWEEP_DWELL  cycles per step while sweeping (2..2^24-1)
//     WDOG_CYCLES  command-silence timeout in cycles (2..2^27-1)
//
//   Ports
//     clk   40 MHz clock
//     rst   synchronous, active-high reset
//     bus   uc_cmd_if.slave: cmd/cmd_stb in; freq_idx, drv_en, sweeping,
//           locked, cmd_err, wdog_trip out (all registered)
//
//   Build option
//     UC_CTRL_WDOG_EN  compiles in the command-silence watchdog. Without it
//                      wdog_trip is tied low and drive persists indefinitely.
module uc_cmd_ctrl #(
  parameter int unsigned SWEEP_DWELL = 400000,
  parameter int unsigned WDOG_CYCLES = 40000000
) (
  input  logic     clk,
  input  logic     rst,
  uc_cmd_if.slave  bus
);

  if (SWEEP_DWELL < 2 || SWEEP_DWELL > 32'h00FF_FFFF) begin : g_bad_dwell
    $error("uc_cmd_ctrl: SWEEP_DWELL out of range");
  end
  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 32'h07FF_FFFF) begin : g_bad_wdog
    $error("uc_cmd_ctrl: WDOG_CYCLES out of range");
  end

  localparam logic [4:0]  FREQ_MAX   = 5'd20;
  localparam logic [4:0]  CMD_RUN    = 5'd21;
  localparam logic [4:0]  CMD_STOP   = 5'd22;
  localparam logic [4:0]  CMD_SWEEP  = 5'd23;
  localparam logic [4:0]  CMD_LOCK   = 5'd24;
  localparam logic [23:0] DWELL_LAST = 24'(SWEEP_DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  // One triangle step; returns {dir, idx}. Endpoints bounce without a
  // repeat, so idx is kept inside 0..20.
  function automatic logic [5:0] sweep_step(input logic [4:0] idx,
                                            input logic       up);
    logic [5:0] res;
    if (up) begin
      if (idx >= FREQ_MAX) res = {1'b0, FREQ_MAX - 5'd1};
      else                 res = {1'b1, idx + 5'd1};
    end else begin
      if (idx == 5'd0)     res = {1'b1, 5'd1};
      else                 res = {1'b0, idx - 5'd1};
    end
    return res;
  endfunction

  state_t      state_p0,    state_p1;
  logic [4:0]  freq_idx_p0, freq_idx_p1;
  logic [4:0]  freq_set_p0, freq_set_p1;
  logic        dir_p0,      dir_p1;
  logic [23:0] dwell_p0,    dwell_p1;
  logic        cmd_err_p0,  cmd_err_p1;
  logic        step_due;
`ifdef UC_CTRL_WDOG_EN
  localparam logic [26:0] WDOG_LAST = 27'(WDOG_CYCLES - 1);
  logic [26:0] wdog_cnt_p0, wdog_cnt_p1;
  logic        wdog_trip_p0, wdog_trip_p1;
`endif

  // ---- stage p0: command decode, sweep timebase, next-state ----
  always_comb begin
    state_p0    = state_p1;
    freq_idx_p0 = freq_idx_p1;
    freq_set_p0 = freq_set_p1;
    dir_p0      = dir_p1;
    dwell_p0    = dwell_p1;
    cmd_err_p0  = 1'b0;
    step_due    = (state_p1 == ST_SWEEP) && (dwell_p1 == DWELL_LAST);
`ifdef UC_CTRL_WDOG_EN
    wdog_cnt_p0  = wdog_cnt_p1;
    wdog_trip_p0 = 1'b0;
`endif

    if (state_p1 == ST_SWEEP) begin
      if (step_due) begin
        dwell_p0 = '0;
        {dir_p0, freq_idx_p0} = sweep_step(freq_idx_p1, dir_p1);
      end else begin
        dwell_p0 = dwell_p1 + 24'd1;
      end
    end

    // A strobe overrides the sweep step computed above, except that a plain
    // frequency code while sweeping only retargets freq_set.
    if (bus.cmd_stb) begin
      if (bus.cmd <= FREQ_MAX) begin
        case (state_p1)
          ST_IDLE:  freq_set_p0 = bus.cmd;
          ST_RUN: begin
            freq_set_p0 = bus.cmd;
            freq_idx_p0 = bus.cmd;
          end
          ST_SWEEP: freq_set_p0 = bus.cmd;
          default: ;
        endcase
      end else begin
        case (bus.cmd)
          CMD_RUN: begin
            if (state_p1 == ST_IDLE || state_p1 == ST_SWEEP) begin
              state_p0    = ST_RUN;
              freq_idx_p0 = freq_set_p1;
              dir_p0      = dir_p1;
              dwell_p0    = '0;
            end
          end
          CMD_STOP: begin
            state_p0    = ST_IDLE;
            freq_idx_p0 = freq_idx_p1;
            dir_p0      = dir_p1;
            dwell_p0    = '0;
          end
          CMD_SWEEP: begin
            if (state_p1 != ST_LOCK) begin
              state_p0    = ST_SWEEP;
              freq_idx_p0 = '0;
              dir_p0      = 1'b1;
              dwell_p0    = '0;
            end
          end
          CMD_LOCK: begin
            if (state_p1 == ST_RUN || state_p1 == ST_SWEEP) begin
              state_p0    = ST_LOCK;
              freq_idx_p0 = freq_idx_p1;
              dir_p0      = dir_p1;
              dwell_p0    = '0;
            end
          end
          default: begin
            // Invalid code: flag it and drop any coincident step.
            cmd_err_p0  = 1'b1;
            freq_idx_p0 = freq_idx_p1;
            dir_p0      = dir_p1;
          end
        endcase
      end
    end

`ifdef UC_CTRL_WDOG_EN
    // Silence counter runs only while driving; any strobe restarts it and
    // wins over a coincident expiry.
    if (bus.cmd_stb || state_p1 == ST_IDLE) begin
      wdog_cnt_p0 = '0;
    end else if (wdog_cnt_p1 == WDOG_LAST) begin
      wdog_cnt_p0  = '0;
      wdog_trip_p0 = 1'b1;
      state_p0     = ST_IDLE;
      freq_idx_p0  = freq_idx_p1;
      dir_p0       = dir_p1;
      dwell_p0     = '0;
    end else begin
      wdog_cnt_p0 = wdog_cnt_p1 + 27'd1;
    end
`endif
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= ST_IDLE;
      freq_idx_p1 <= '0;
      freq_set_p1 <= '0;
      dir_p1      <= 1'b1;
      dwell_p1    <= '0;
      cmd_err_p1  <= 1'b0;
`ifdef UC_CTRL_WDOG_EN
      wdog_cnt_p1  <= '0;
      wdog_trip_p1 <= 1'b0;
`endif
    end else begin
      state_p1    <= state_p0;
      freq_idx_p1 <= freq_idx_p0;
      freq_set_p1 <= freq_set_p0;
      dir_p1      <= dir_p0;
      dwell_p1    <= dwell_p0;
      cmd_err_p1  <= cmd_err_p0;
`ifdef UC_CTRL_WDOG_EN
      wdog_cnt_p1  <= wdog_cnt_p0;
      wdog_trip_p1 <= wdog_trip_p0;
`endif
    end
  end

  assign bus.freq_idx = freq_idx_p1;
  assign bus.drv_en   = (state_p1 != ST_IDLE);
  assign bus.sweeping = (state_p1 == ST_SWEEP);
  assign bus.locked   = (state_p1 == ST_LOCK);
  assign bus.cmd_err  = cmd_err_p1;
`ifdef UC_CTRL_WDOG_EN
  assign bus.wdog_trip = wdog_trip_p1;
`else
  assign bus.wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_uc_cmd_ctrl.sv
// tb_uc_cmd_ctrl
//   Directed self-checking bench for uc_cmd_ctrl with SWEEP_DWELL=4 and
//   WDOG_CYCLES=100. Inputs change on the falling edge; outputs are
//   sampled on the falling edge, half a cycle after the active edge.
module tb_uc_cmd_ctrl;

  localparam logic [4:0] C_RUN   = 5'd21;
  localparam logic [4:0] C_STOP  = 5'd22;
  localparam logic [4:0] C_SWEEP = 5'd23;
  localparam logic [4:0] C_LOCK  = 5'd24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uc_cmd_if bus ();

  uc_cmd_ctrl #(
    .SWEEP_DWELL (4),
    .WDOG_CYCLES (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // {drv_en, sweeping, locked, cmd_err, freq_idx}
  logic [8:0] obs;
  assign obs = {bus.drv_en, bus.sweeping, bus.locked, bus.cmd_err, bus.freq_idx};

  // Called at a falling edge; holds the strobe for one active edge and
  // returns at the next falling edge, where the effect is visible.
  task automatic strobe(input logic [4:0] code);
    bus.cmd     = code;
    bus.cmd_stb = 1'b1;
    @(negedge clk);
    bus.cmd_stb = 1'b0;
    bus.cmd     = 5'd0;
  endtask

  task automatic do_reset;
    rst         = 1'b1;
    bus.cmd     = 5'd0;
    bus.cmd_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (obs !== 9'h000 || bus.wdog_trip !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b, want 000/0", obs, bus.wdog_trip);
    end
  endtask

  task automatic test_run;
    do_reset();
    strobe(5'd12);
    checks++;
    if (obs !== {4'b0000, 5'd0}) begin
      errors++; $display("FAIL run_idle_freq: got %h, want %h", obs, {4'b0000, 5'd0});
    end
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd12}) begin
      errors++; $display("FAIL run_enter: got %h, want %h", obs, {4'b1000, 5'd12});
    end
    strobe(5'd5);
    checks++;
    if (obs !== {4'b1000, 5'd5}) begin
      errors++; $display("FAIL run_retune: got %h, want %h", obs, {4'b1000, 5'd5});
    end
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd5}) begin
      errors++; $display("FAIL run_in_run: got %h, want %h", obs, {4'b1000, 5'd5});
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    strobe(5'd3);
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd3}) begin
      errors++; $display("FAIL b2b_run: got %h, want %h", obs, {4'b1000, 5'd3});
    end
    strobe(5'd8);
    checks++;
    if (obs !== {4'b1000, 5'd8}) begin
      errors++; $display("FAIL b2b_freq: got %h, want %h", obs, {4'b1000, 5'd8});
    end
    strobe(C_STOP);
    checks++;
    if (obs !== {4'b0000, 5'd8}) begin
      errors++; $display("FAIL b2b_stop: got %h, want %h", obs, {4'b0000, 5'd8});
    end
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd8}) begin
      errors++; $display("FAIL b2b_rerun: got %h, want %h", obs, {4'b1000, 5'd8});
    end
  endtask

  task automatic test_sweep;
    logic [4:0] exp;
    do_reset();
    strobe(5'd5);
    strobe(C_SWEEP);
    for (int i = 0; i < 42; i++) begin
      if (i <= 20)      exp = 5'(i);
      else if (i <= 40) exp = 5'(40 - i);
      else              exp = 5'd1;
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obs !== {4'b1100, exp}) begin
          errors++;
          $display("FAIL sweep_seq step %0d cyc %0d: got %h, want %h", i, j, obs, {4'b1100, exp});
        end
        @(negedge clk);
      end
    end
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd5}) begin
      errors++; $display("FAIL sweep_to_run: got %h, want %h", obs, {4'b1000, 5'd5});
    end
  endtask

  task automatic test_lock;
    bit found;
    do_reset();
    strobe(C_LOCK);
    checks++;
    if (obs !== 9'h000) begin
      errors++; $display("FAIL lock_from_idle: got %h, want 000", obs);
    end
    strobe(C_SWEEP);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (bus.freq_idx === 5'd7) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL lock_reach7: got freq_idx %0d, want 7 within 200 cycles", bus.freq_idx);
    end
    strobe(C_LOCK);
    checks++;
    if (obs !== {4'b1010, 5'd7}) begin
      errors++; $display("FAIL lock_enter: got %h, want %h", obs, {4'b1010, 5'd7});
    end
    strobe(5'd15);
    strobe(C_RUN);
    repeat (8) @(negedge clk);
    checks++;
    if (obs !== {4'b1010, 5'd7}) begin
      errors++; $display("FAIL lock_hold: got %h, want %h", obs, {4'b1010, 5'd7});
    end
    strobe(C_STOP);
    checks++;
    if (obs !== {4'b0000, 5'd7}) begin
      errors++; $display("FAIL lock_stop: got %h, want %h", obs, {4'b0000, 5'd7});
    end
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd0}) begin
      errors++; $display("FAIL lock_ignored_freq: got %h, want %h", obs, {4'b1000, 5'd0});
    end
  endtask

  task automatic test_cmd_err;
    do_reset();
    strobe(5'd9);
    strobe(C_RUN);
    strobe(5'd27);
    checks++;
    if (obs !== {4'b1001, 5'd9}) begin
      errors++; $display("FAIL err_pulse_run: got %h, want %h", obs, {4'b1001, 5'd9});
    end
    @(negedge clk);
    checks++;
    if (obs !== {4'b1000, 5'd9}) begin
      errors++; $display("FAIL err_one_cycle: got %h, want %h", obs, {4'b1000, 5'd9});
    end
    strobe(C_STOP);
    strobe(5'd31);
    checks++;
    if (obs !== {4'b0001, 5'd9}) begin
      errors++; $display("FAIL err_pulse_idle: got %h, want %h", obs, {4'b0001, 5'd9});
    end
    @(negedge clk);
    checks++;
    if (obs !== {4'b0000, 5'd9}) begin
      errors++; $display("FAIL err_clear_idle: got %h, want %h", obs, {4'b0000, 5'd9});
    end
  endtask

  task automatic test_expiry_priority;
    do_reset();
    strobe(C_SWEEP);
    repeat (7) @(negedge clk);
    checks++;
    if (obs !== {4'b1100, 5'd1}) begin
      errors++; $display("FAIL exp_pre_stop: got %h, want %h", obs, {4'b1100, 5'd1});
    end
    strobe(C_STOP);
    checks++;
    if (obs !== {4'b0000, 5'd1}) begin
      errors++; $display("FAIL exp_stop_wins: got %h, want %h", obs, {4'b0000, 5'd1});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs !== {4'b0000, 5'd1}) begin
      errors++; $display("FAIL exp_idle_hold: got %h, want %h", obs, {4'b0000, 5'd1});
    end
    strobe(C_SWEEP);
    repeat (3) @(negedge clk);
    strobe(5'd9);
    checks++;
    if (obs !== {4'b1100, 5'd1}) begin
      errors++; $display("FAIL exp_freq_steps: got %h, want %h", obs, {4'b1100, 5'd1});
    end
    repeat (3) @(negedge clk);
    strobe(C_LOCK);
    checks++;
    if (obs !== {4'b1010, 5'd1}) begin
      errors++; $display("FAIL exp_lock_wins: got %h, want %h", obs, {4'b1010, 5'd1});
    end
    strobe(C_STOP);
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd9}) begin
      errors++; $display("FAIL exp_freq_set: got %h, want %h", obs, {4'b1000, 5'd9});
    end
  endtask

  task automatic test_rst_mid_sweep;
    do_reset();
    strobe(5'd6);
    strobe(C_SWEEP);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 9'h000 || bus.wdog_trip !== 1'b0) begin
      errors++; $display("FAIL rst_mid_sweep: got %h/%b, want 000/0", obs, bus.wdog_trip);
    end
    rst = 1'b0;
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd0}) begin
      errors++; $display("FAIL rst_clears_set: got %h, want %h", obs, {4'b1000, 5'd0});
    end
  endtask

`ifdef UC_CTRL_WDOG_EN
  task automatic test_watchdog;
    do_reset();
    strobe(5'd4);
    strobe(C_RUN);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if (bus.wdog_trip !== 1'b0 || bus.drv_en !== 1'b1) begin
        errors++;
        $display("FAIL wdog_early cyc %0d: got trip %b drv %b, want 0 1", k, bus.wdog_trip, bus.drv_en);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.wdog_trip !== 1'b1 || bus.drv_en !== 1'b0) begin
      errors++; $display("FAIL wdog_trip: got trip %b drv %b, want 1 0", bus.wdog_trip, bus.drv_en);
    end
    @(negedge clk);
    checks++;
    if (bus.wdog_trip !== 1'b0 || bus.drv_en !== 1'b0) begin
      errors++; $display("FAIL wdog_pulse: got trip %b drv %b, want 0 0", bus.wdog_trip, bus.drv_en);
    end
    strobe(C_RUN);
    checks++;
    if (obs !== {4'b1000, 5'd4}) begin
      errors++; $display("FAIL wdog_keeps_set: got %h, want %h", obs, {4'b1000, 5'd4});
    end
    do_reset();
    strobe(C_RUN);
    repeat (99) @(negedge clk);
    strobe(5'd12);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (bus.wdog_trip !== 1'b0 || obs !== {4'b1000, 5'd12}) begin
        errors++;
        $display("FAIL wdog_saved cyc %0d: got trip %b obs %h, want 0 %h", k, bus.wdog_trip, obs, {4'b1000, 5'd12});
      end
      @(negedge clk);
    end
  endtask
`else
  task automatic test_watchdog;
    do_reset();
    strobe(C_RUN);
    for (int k = 0; k < 150; k++) begin
      checks++;
      if (bus.wdog_trip !== 1'b0 || bus.drv_en !== 1'b1) begin
        errors++;
        $display("FAIL no_wdog cyc %0d: got trip %b drv %b, want 0 1", k, bus.wdog_trip, bus.drv_en);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    bus.cmd     = 5'd0;
    bus.cmd_stb = 1'b0;
    @(negedge clk);
    test_reset();
    test_run();
    test_back_to_back();
    test_sweep();
    test_lock();
    test_cmd_err();
    test_expiry_priority();
    test_rst_mid_sweep();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uc_cmd_ctrl.md
# uc_cmd_ctrl

- Generator-side controller fed by the serial command receiver's decoded 5-bit command code.
- Sequences the ultrasonic drive through idle, fixed-frequency run, triangular frequency sweep and frequency lock.
- Output is the frequency step index (0..20 = 30.0..40.0 kHz in 0.5 kHz steps) and drive enable for the downstream oscillator.
- Sits between the command receiver and the NCO/driver stage on the 40 MHz domain.

## Interface

Parameters:
- SWEEP_DWELL, 400000: cycles spent on each step while sweeping (10 ms at 40 MHz). Legal range 2..2^24-1.
- WDOG_CYCLES, 40000000: command-silence timeout in cycles (1 s). Legal range 2..2^27-1. Used only with the watchdog compiled in.

Ports:
- clk, input, 1: 40 MHz clock.
- rst, input, 1: synchronous, active-high reset.
- cmd, input, 5: decoded command code.
  - 0..20: frequency step.
  - 21: RUN.
  - 22: STOP.
  - 23: SWEEP.
  - 24: LOCK.
  - 25..31: invalid.
- cmd_stb, input, 1: one-cycle strobe. cmd is valid when it is high.
- freq_idx, output, 5: frequency step currently driven.
- drv_en, output, 1: drive enable.
- sweeping, output, 1: high while in SWEEP.
- locked, output, 1: high while in LOCK.
- cmd_err, output, 1: one-cycle pulse on an invalid code.
- wdog_trip, output, 1: one-cycle pulse on a watchdog timeout. Tied 0 when the watchdog is not compiled in.

## Operation

States:
- IDLE: drv_en=0.
- RUN: drv_en=1, freq_idx=freq_set.
- SWEEP: drv_en=1, sweeping=1.
- LOCK: drv_en=1, locked=1, freq_idx frozen.

Internal registers:
- freq_set (5 bits): last accepted frequency step.
- dir (1 = up).
- dwell counter (24 bits).

Command handling (only on cmd_stb=1):
- Code 0..20:
  - IDLE: freq_set<=code.
  - RUN: freq_set<=code and freq_idx<=code.
  - SWEEP: freq_set<=code. Sweep continues unchanged.
  - LOCK: ignored.
- RUN (21):
  - From IDLE or SWEEP: go to RUN with freq_idx<=freq_set.
  - In RUN or LOCK: ignored.
- STOP (22): any state goes to IDLE. freq_idx and freq_set are retained.
- SWEEP (23):
  - From IDLE or RUN: go to SWEEP with freq_idx<=0, dir<=up, dwell<=0.
  - In SWEEP: restart the sweep the same way.
  - In LOCK: ignored.
- LOCK (24):
  - From RUN or SWEEP: go to LOCK and freeze the current freq_idx.
  - From IDLE or LOCK: ignored.
- Code 25..31: cmd_err pulses. No other register changes.

Sweep stepping:
- The dwell counter counts 0..SWEEP_DWELL-1. A step occurs when it reaches SWEEP_DWELL-1, and it then wraps to 0.
- Step with dir=up:
  - If freq_idx<20: freq_idx+1.
  - If freq_idx=20: freq_idx=19 and dir<=down.
- Step with dir=down:
  - If freq_idx>0: freq_idx-1.
  - If freq_idx=0: freq_idx=1 and dir<=up.
- The result is a triangle 0→20→0 with no repeated endpoints.
- freq_idx never leaves 0..20.

## Timing

- All outputs are registered. Effects of a strobe are visible on the edge after the cmd_stb cycle, so latency is 1 cycle.
- Back-to-back strobes are each processed. Nothing is queued.
- In SWEEP, the first step is SWEEP_DWELL cycles after the entry edge. Later steps come every SWEEP_DWELL cycles.
- If cmd_stb and dwell expiry fall in the same cycle, the command takes priority and that sweep step is discarded. For a code 0..20 in SWEEP, freq_set is updated and the step still occurs.
- Reset values: freq_idx=0, freq_set=0, dir=up, dwell=0, drv_en=0, sweeping=0, locked=0, cmd_err=0, wdog_trip=0, state=IDLE.
- Reset asserted mid-sweep or mid-run gives reset values on the next edge.

## Configuration

- Macro: UC_CTRL_WDOG_EN.
- Defined:
  - A 27-bit silence counter clears on every cmd_stb (any code) and while drv_en=0.
  - When it reaches WDOG_CYCLES-1 with drv_en=1, the block goes to IDLE and pulses wdog_trip for 1 cycle. freq_set is kept.
  - If a strobe arrives on the expiry cycle, the strobe wins and no trip occurs.
- Undefined: no counter is built, wdog_trip=0, and drive persists indefinitely.

## Test plan

- Reset, then strobe 12, then RUN: freq_idx=12 and drv_en=1 one cycle after the RUN strobe. Then strobe 5: freq_idx=5.
- SWEEP with SWEEP_DWELL=4: freq_idx follows 0,1,…,20,19,…,0,1, changing every 4 cycles. sweeping=1 throughout.
- SWEEP, then LOCK at freq_idx=7, then strobe 15 and RUN: freq_idx stays 7 and locked=1. Then STOP: drv_en=0, freq_idx=7.
- Strobe 27 in RUN: cmd_err pulses exactly 1 cycle, with state and freq_idx unchanged.
- Dwell expiry coinciding with a STOP strobe: state goes to IDLE and freq_idx is not stepped. Assert rst mid-sweep: all outputs take reset values on the next edge.
- With UC_CTRL_WDOG_EN and WDOG_CYCLES=100: RUN with no further strobes gives wdog_trip 100 cycles later and drv_en=0. A strobe at cycle 99 prevents the trip.
